// File: rtl/ms_game_ctrl_pkg.sv
// ms_game_ctrl_pkg
// Shared definitions for the minesweeper game-flow controller: state codes
// (also used by the display logic) and a small helper deciding when the board
// must ignore clicks.
// No ports; import with ms_game_ctrl_pkg::*.
package ms_game_ctrl_pkg;

  localparam int ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_PLAY  = 3'd2,
    ST_WON   = 3'd3,
    ST_LOST  = 3'd4
  } ms_state_t;

  // The board is frozen whenever no game is in progress.
  function automatic logic is_locked(input ms_state_t s);
    return (s == ST_IDLE) || (s == ST_WON) || (s == ST_LOST);
  endfunction

endpackage

// File: rtl/ms_game_ctrl_tick.sv
// ms_tick_gen
// Free-running prescaler producing the one-second step pulse for ms_timer.
// Only the synchronous reset restarts it; a new game does not.
// Ports:
//   clk      in  1  system clock
//   clr      in  1  synchronous active-high reset
//   sec_tick out 1  registered one-cycle pulse, high while count == DIV-1
module ms_tick_gen #(
  parameter int DIV  = 50_000_000,
  parameter int DBIT = 26
) (
  input  logic clk,
  input  logic clr,
  output logic sec_tick
);

  logic [DBIT-1:0] count;

  // sec_tick is registered one count early so it is high exactly while
  // count sits at DIV-1 (requires DIV >= 2).
  always_ff @(posedge clk) begin
    if (clr) begin
      count    <= '0;
      sec_tick <= 1'b0;
    end else begin
      if (count == DBIT'(DIV - 1)) count <= '0;
      else                         count <= count + 1'b1;
      sec_tick <= (count == DBIT'(DIV - 2));
    end
  end

endmodule

// File: rtl/ms_game_ctrl.sv
// ms_game_ctrl
// Minesweeper game-flow controller. Sequences ms_timer (clear/start/stop
// strobes stretched until the next sec_tick), counts revealed safe cells and
// placed flags, and decides win / lose / timeout.
// Ports:
//   clk, clr                 clock and synchronous active-high reset
//   btn_new                  new-game button level; rising edge acts
//   reveal_vld, reveal_mine  reveal strobe and its "was a mine" qualifier
//   flag_tgl, flag_set       flag strobe and its placed(1)/removed(0) qualifier
//   time_q                   current ms_timer count
//   sec_tick                 one-cycle pulse every DIV clocks
//   tmr_clr/start/stop       stretched strobes to ms_timer
//   state                    IDLE=0 ARMED=1 PLAY=2 WON=3 LOST=4
//   board_lock               board ignores clicks when high
//   mines_left               MINES minus flags, clamped at 0
//   win_p, lose_p            one-cycle pulses on entering WON / LOST
module ms_game_ctrl
  import ms_game_ctrl_pkg::*;
#(
  parameter int CELLS  = 256,
  parameter int CBIT   = 9,
  parameter int MINES  = 40,
  parameter int MBIT   = 7,
  parameter int DIV    = 50_000_000,
  parameter int DBIT   = 26,
  parameter int TLIMIT = 599,
  parameter int BIT    = 10
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            btn_new,
  input  logic            reveal_vld,
  input  logic            reveal_mine,
  input  logic            flag_tgl,
  input  logic            flag_set,
  input  logic [BIT-1:0]  time_q,
  output logic            sec_tick,
  output logic            tmr_clr,
  output logic            tmr_start,
  output logic            tmr_stop,
  output logic [2:0]      state,
  output logic            board_lock,
  output logic [MBIT-1:0] mines_left,
  output logic            win_p,
  output logic            lose_p
);

  localparam logic [CBIT-1:0] WIN_CNT  = CBIT'(CELLS - MINES);
  localparam logic [MBIT-1:0] MINES_W  = MBIT'(MINES);
  localparam logic [BIT-1:0]  TLIMIT_W = BIT'(TLIMIT);

  ms_state_t       state_q, state_d;
  logic            btn_q;
  logic [CBIT-1:0] revealed_q, revealed_d, revealed_inc;
  logic [MBIT-1:0] flags_q, flags_d;
  logic            req_clr, req_start, req_stop;
  logic            new_game, timeout, active;

  ms_tick_gen #(.DIV(DIV), .DBIT(DBIT)) u_tick (
    .clk      (clk),
    .clr      (clr),
    .sec_tick (sec_tick)
  );

  assign new_game     = btn_new & ~btn_q;
  assign timeout      = sec_tick && (time_q == TLIMIT_W);
  assign active       = (state_q == ST_ARMED) || (state_q == ST_PLAY);
  assign revealed_inc = revealed_q + 1'b1;
  assign state        = state_q;

  // State register and button history.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_IDLE;
      btn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      btn_q   <= btn_new;
    end
  end

  // Next state; order of tests encodes new > mine > win > timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (new_game) state_d = ST_ARMED;
      ST_ARMED: begin
        if (new_game)        state_d = ST_ARMED;
        else if (reveal_vld) state_d = reveal_mine ? ST_LOST : ST_PLAY;
      end
      ST_PLAY: begin
        if (new_game)                                state_d = ST_ARMED;
        else if (reveal_vld && reveal_mine)          state_d = ST_LOST;
        else if (reveal_vld && revealed_inc == WIN_CNT) state_d = ST_WON;
        else if (timeout)                            state_d = ST_LOST;
      end
      ST_WON, ST_LOST: if (new_game) state_d = ST_ARMED;
      default: state_d = ST_IDLE;
    endcase
  end

  // Counter updates and timer requests derived from the transition taken.
  // Entering ARMED (including re-arming) wipes the counters, so a flag or
  // reveal in the same cycle as a new game is dropped.
  always_comb begin
    revealed_d = revealed_q;
    flags_d    = flags_q;
    req_clr    = 1'b0;
    req_start  = 1'b0;
    req_stop   = 1'b0;
    if (state_d == ST_ARMED && (state_q != ST_ARMED || new_game)) begin
      revealed_d = '0;
      flags_d    = '0;
      req_clr    = 1'b1;
      if (state_q == ST_PLAY) req_stop = 1'b1;
    end else if (active) begin
      if (reveal_vld && !reveal_mine) revealed_d = revealed_inc;
      if (flag_tgl) begin
        if (flag_set && flags_q != '1)       flags_d = flags_q + 1'b1;
        else if (!flag_set && flags_q != '0) flags_d = flags_q - 1'b1;
      end
      if (state_q == ST_ARMED && state_d == ST_PLAY) req_start = 1'b1;
      if (state_q == ST_PLAY && (state_d == ST_WON || state_d == ST_LOST))
        req_stop = 1'b1;
    end
  end

  // Registered outputs. A timer strobe stays up until a cycle with sec_tick
  // has passed, so the slow timer is sure to see it; a fresh request replaces
  // any pending one, with clear beating start beating stop.
  always_ff @(posedge clk) begin
    if (clr) begin
      revealed_q <= '0;
      flags_q    <= '0;
      board_lock <= 1'b1;
      mines_left <= MINES_W;
      win_p      <= 1'b0;
      lose_p     <= 1'b0;
      tmr_clr    <= 1'b0;
      tmr_start  <= 1'b0;
      tmr_stop   <= 1'b0;
    end else begin
      revealed_q <= revealed_d;
      flags_q    <= flags_d;
      board_lock <= is_locked(state_d);
      mines_left <= (flags_d >= MINES_W) ? '0 : MINES_W - flags_d;
      win_p      <= (state_d == ST_WON)  && (state_q != ST_WON);
      lose_p     <= (state_d == ST_LOST) && (state_q != ST_LOST);
      if (req_clr)        {tmr_clr, tmr_start, tmr_stop} <= 3'b100;
      else if (req_start) {tmr_clr, tmr_start, tmr_stop} <= 3'b010;
      else if (req_stop)  {tmr_clr, tmr_start, tmr_stop} <= 3'b001;
      else if (sec_tick)  {tmr_clr, tmr_start, tmr_stop} <= 3'b000;
    end
  end

endmodule

// File: tb/tb_ms_game_ctrl.sv
// tb_ms_game_ctrl
// Directed bench for ms_game_ctrl with a small board (16 cells, 3 mines),
// a 4-clock second and a timeout at timer value 5.
module tb_ms_game_ctrl;

  localparam int DIV = 4;
  localparam int REQ_NONE = 0, REQ_CLR = 1, REQ_START = 2, REQ_STOP = 3;

  logic       clk = 1'b0;
  logic       clr, btn_new, reveal_vld, reveal_mine, flag_tgl, flag_set;
  logic [9:0] time_q;
  logic       sec_tick, tmr_clr, tmr_start, tmr_stop;
  logic [2:0] state;
  logic       board_lock, win_p, lose_p;
  logic [2:0] mines_left;

  int tests_run = 0;
  int tests_failed = 0;
  int edges = 0;
  logic exp_clr = 1'b0, exp_start = 1'b0, exp_stop = 1'b0;
  logic hit;

  ms_game_ctrl #(
    .CELLS(16), .CBIT(5), .MINES(3), .MBIT(3),
    .DIV(DIV), .DBIT(2), .TLIMIT(5), .BIT(10)
  ) dut (
    .clk(clk), .clr(clr), .btn_new(btn_new), .reveal_vld(reveal_vld),
    .reveal_mine(reveal_mine), .flag_tgl(flag_tgl), .flag_set(flag_set),
    .time_q(time_q), .sec_tick(sec_tick), .tmr_clr(tmr_clr),
    .tmr_start(tmr_start), .tmr_stop(tmr_stop), .state(state),
    .board_lock(board_lock), .mines_left(mines_left), .win_p(win_p),
    .lose_p(lose_p)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input int act, input int exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic tick_now();
    return (edges % DIV) == DIV - 1;
  endfunction

  // One clock: inputs already driven, outputs sampled 1 time unit after the
  // edge. Tracks prescaler phase and the expected stretched timer strobes.
  task automatic apply_stimulus(input int req);
    logic cur_tick;
    cur_tick = clr ? 1'b0 : tick_now();
    @(posedge clk);
    #1;
    if (clr) begin
      edges = 0;
      {exp_clr, exp_start, exp_stop} = 3'b000;
    end else begin
      edges++;
      if (req == REQ_CLR)        {exp_clr, exp_start, exp_stop} = 3'b100;
      else if (req == REQ_START) {exp_clr, exp_start, exp_stop} = 3'b010;
      else if (req == REQ_STOP)  {exp_clr, exp_start, exp_stop} = 3'b001;
      else if (cur_tick)         {exp_clr, exp_start, exp_stop} = 3'b000;
    end
  endtask

  task automatic check_tmr(input string tag);
    check_output({tag, "_tmr_clr"},   int'(tmr_clr),   int'(exp_clr));
    check_output({tag, "_tmr_start"}, int'(tmr_start), int'(exp_start));
    check_output({tag, "_tmr_stop"},  int'(tmr_stop),  int'(exp_stop));
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_state"},      int'(state),      0);
    check_output({tag, "_board_lock"}, int'(board_lock), 1);
    check_output({tag, "_mines_left"}, int'(mines_left), 3);
    check_output({tag, "_win_p"},      int'(win_p),      0);
    check_output({tag, "_lose_p"},     int'(lose_p),     0);
    check_output({tag, "_sec_tick"},   int'(sec_tick),   0);
    check_output({tag, "_tmr_clr"},    int'(tmr_clr),    0);
    check_output({tag, "_tmr_start"},  int'(tmr_start),  0);
    check_output({tag, "_tmr_stop"},   int'(tmr_stop),   0);
  endtask

  task automatic new_game(input int req);
    btn_new = 1'b1;
    apply_stimulus(req);
    btn_new = 1'b0;
  endtask

  task automatic reveal(input logic mine, input int req);
    reveal_vld = 1'b1;
    reveal_mine = mine;
    apply_stimulus(req);
    reveal_vld = 1'b0;
    reveal_mine = 1'b0;
  endtask

  task automatic flag(input logic set);
    flag_tgl = 1'b1;
    flag_set = set;
    apply_stimulus(REQ_NONE);
    flag_tgl = 1'b0;
  endtask

  initial begin
    clr = 1'b1; btn_new = 1'b0; reveal_vld = 1'b0; reveal_mine = 1'b0;
    flag_tgl = 1'b0; flag_set = 1'b0; time_q = '0;

    // Reset values.
    apply_stimulus(REQ_NONE);
    apply_stimulus(REQ_NONE);
    check_reset_values("reset");
    clr = 1'b0;

    // Prescaler cadence: tick on every 4th clock after release.
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(REQ_NONE);
      check_output("tick_cadence", int'(sec_tick), int'(tick_now()));
    end

    // Flags and reveals ignored while idle.
    flag(1'b1);
    check_output("idle_flag_ignored", int'(mines_left), 3);
    reveal(1'b0, REQ_NONE);
    check_output("idle_reveal_ignored", int'(state), 0);

    // New game: ARMED with stretched clear; held button does not retrigger.
    btn_new = 1'b1;
    apply_stimulus(REQ_CLR);
    check_output("armed_state", int'(state), 1);
    check_output("armed_lock", int'(board_lock), 0);
    check_tmr("armed");
    apply_stimulus(REQ_NONE);
    check_tmr("armed_hold");
    btn_new = 1'b0;
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(REQ_NONE);
      check_tmr("clr_stretch");
    end

    // First safe reveal starts play and the timer.
    reveal(1'b0, REQ_START);
    check_output("play_state", int'(state), 2);
    check_tmr("play_start");
    for (int i = 2; i <= 12; i++) begin
      reveal(1'b0, REQ_NONE);
      check_output("play_reveals", int'(state), 2);
      check_tmr("start_stretch");
    end

    // 13th safe cell wins.
    reveal(1'b0, REQ_STOP);
    check_output("won_state", int'(state), 3);
    check_output("won_win_p", int'(win_p), 1);
    check_output("won_lock", int'(board_lock), 1);
    check_tmr("won");
    reveal(1'b0, REQ_NONE);
    check_output("won_reveal_ignored", int'(state), 3);
    check_output("won_win_p_drop", int'(win_p), 0);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(REQ_NONE);
      check_tmr("stop_stretch");
    end

    // Flag counting with saturation at zero.
    new_game(REQ_CLR);
    check_output("rearm_state", int'(state), 1);
    for (int i = 1; i <= 5; i++) begin
      flag(1'b1);
      check_output("flag_place", int'(mines_left), (i >= 3) ? 0 : 3 - i);
    end
    for (int i = 4; i >= 0; i--) begin
      flag(1'b0);
      check_output("flag_remove", int'(mines_left), (i >= 3) ? 0 : 3 - i);
    end
    flag(1'b0);
    check_output("flag_floor", int'(mines_left), 3);

    // Mine during play loses.
    reveal(1'b0, REQ_START);
    flag(1'b1);
    check_output("play_flag", int'(mines_left), 2);
    reveal(1'b1, REQ_STOP);
    check_output("lost_state", int'(state), 4);
    check_output("lost_lose_p", int'(lose_p), 1);
    check_output("lost_lock", int'(board_lock), 1);
    check_tmr("lost");
    apply_stimulus(REQ_NONE);
    check_output("lost_lose_p_drop", int'(lose_p), 0);

    // New game from LOST clears counters.
    new_game(REQ_CLR);
    check_output("relaunch_state", int'(state), 1);
    check_output("relaunch_mines", int'(mines_left), 3);
    check_tmr("relaunch");

    // Timeout only when time_q hits the limit on a tick.
    reveal(1'b0, REQ_START);
    time_q = 10'd5;
    hit = 1'b0;
    for (int i = 0; i < 6 && !hit; i++) begin
      if (tick_now()) begin
        apply_stimulus(REQ_STOP);
        check_output("timeout_state", int'(state), 4);
        check_output("timeout_lose_p", int'(lose_p), 1);
        check_tmr("timeout");
        hit = 1'b1;
      end else begin
        apply_stimulus(REQ_NONE);
        check_output("no_tick_no_timeout", int'(state), 2);
      end
    end
    if (!hit) check_output("timeout_reached", 0, 1);
    time_q = '0;

    // New and mine in the same cycle: new wins.
    new_game(REQ_CLR);
    reveal(1'b0, REQ_START);
    btn_new = 1'b1; reveal_vld = 1'b1; reveal_mine = 1'b1;
    apply_stimulus(REQ_CLR);
    btn_new = 1'b0; reveal_vld = 1'b0; reveal_mine = 1'b0;
    check_output("new_beats_mine_state", int'(state), 1);
    check_output("new_beats_mine_lose_p", int'(lose_p), 0);
    check_tmr("new_beats_mine");

    // Reset mid-play.
    reveal(1'b0, REQ_START);
    flag(1'b1);
    check_output("pre_clr_mines", int'(mines_left), 2);
    clr = 1'b1;
    apply_stimulus(REQ_NONE);
    check_reset_values("mid_clr");
    clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(REQ_NONE);
      check_output("tick_after_clr", int'(sec_tick), int'(tick_now()));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
